// File: rtl/axi4_mem_tester_pkg.sv
// Shared types and constants for the AXI4 memory tester.
package axi4_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_ADDR     = 2'd0,
    PAT_INV_ADDR = 2'd1,
    PAT_WALK_ONE = 2'd2,
    PAT_LFSR     = 2'd3
  } pattern_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axi4_mem_tester_if.sv
// AXI4 master-side bundle of the memory tester; signal names keep the
// master's point of view (o_ = driven by the tester, i_ = by the memory).
interface axi4_mem_tester_if #(
  parameter int pAxi4BusWidth = 512,
  parameter int pAdrsWidth    = 33
);
  logic [pAdrsWidth-1:0]      o_awaddr;
  logic [7:0]                 o_awlen;
  logic [2:0]                 o_awsize;
  logic [1:0]                 o_awburst;
  logic                       o_awvalid;
  logic                       i_awready;
  logic [pAxi4BusWidth-1:0]   o_wdata;
  logic [pAxi4BusWidth/8-1:0] o_wstrb;
  logic                       o_wlast;
  logic                       o_wvalid;
  logic                       i_wready;
  logic [1:0]                 i_bresp;
  logic                       i_bvalid;
  logic                       o_bready;
  logic [pAdrsWidth-1:0]      o_araddr;
  logic [7:0]                 o_arlen;
  logic [2:0]                 o_arsize;
  logic [1:0]                 o_arburst;
  logic                       o_arvalid;
  logic                       i_arready;
  logic [pAxi4BusWidth-1:0]   i_rdata;
  logic [1:0]                 i_rresp;
  logic                       i_rlast;
  logic                       i_rvalid;
  logic                       o_rready;

  modport master (
    output o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
    input  i_awready,
    output o_wdata, o_wstrb, o_wlast, o_wvalid,
    input  i_wready,
    input  i_bresp, i_bvalid,
    output o_bready,
    output o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
    input  i_arready,
    input  i_rdata, i_rresp, i_rlast, i_rvalid,
    output o_rready
  );

  modport slave (
    input  o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
    output i_awready,
    input  o_wdata, o_wstrb, o_wlast, o_wvalid,
    output i_wready,
    output i_bresp, i_bvalid,
    input  o_bready,
    input  o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid,
    output i_arready,
    output i_rdata, i_rresp, i_rlast, i_rvalid,
    input  o_rready
  );
endinterface

// File: rtl/mem_pattern_gen.sv
// Registered beat-pattern generator. load re-seeds at a base address,
// advance steps to the next beat; o_data always holds the current beat.
module mem_pattern_gen
  import axi4_mem_tester_pkg::*;
#(
  parameter int pAxi4BusWidth = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     advance,
  input  pattern_e                 mode,
  input  logic [31:0]              address,
  output logic [pAxi4BusWidth-1:0] o_data
);
  localparam int LANES      = pAxi4BusWidth / 32;
  localparam int BEAT_BYTES = pAxi4BusWidth / 8;

  logic [31:0]              addr_q, addr_d;
  logic [4:0]               idx_q, idx_d;
  logic [31:0]              lfsr_q, lfsr_d;
  logic [pAxi4BusWidth-1:0] data_q, data_d;
  logic [31:0]              lane_lfsr, lane_val;

  // Next beat state, and the pattern of that beat so it is registered ahead of use.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    addr_d    = addr_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    data_d    = data_q;
    lane_lfsr = lfsr_q;
    lane_val  = '0;
    if (load) begin
      addr_d    = address;
      idx_d     = '0;
      lane_lfsr = LFSR_SEED;
    end else if (advance) begin
      addr_d = addr_q + 32'(BEAT_BYTES);
      idx_d  = idx_q + 5'd1;
    end
    // Each lane steps the LFSR once; the last lane's value carries into the next beat.
    for (int k = 0; k < LANES; k++) begin
      lane_lfsr = lfsr_step(lane_lfsr);
      case (mode)
        PAT_ADDR:     lane_val = addr_d + 32'(4 * k);
        PAT_INV_ADDR: lane_val = ~(addr_d + 32'(4 * k));
        PAT_WALK_ONE: lane_val = 32'd1 << (idx_d + 5'(k));
        default:      lane_val = lane_lfsr;
      endcase
      if (load || advance) data_d[k*32 +: 32] = lane_val;
    end
    if (load || advance) lfsr_d = lane_lfsr;
  end

  // Generator state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      addr_q <= '0;
      idx_q  <= '0;
      lfsr_q <= LFSR_SEED;
      data_q <= '0;
    end else begin
      addr_q <= addr_d;
      idx_q  <= idx_d;
      lfsr_q <= lfsr_d;
      data_q <= data_d;
    end
  end

  assign o_data = data_q;
endmodule

// File: rtl/axi4_mem_tester.sv
// AXI4 memory tester: writes a pattern over a window, reads it back and compares.
module axi4_mem_tester
  import axi4_mem_tester_pkg::*;
#(
  parameter int                    pAxi4BusWidth = 512,
  parameter int                    pAdrsWidth    = 33,
  parameter logic [pAdrsWidth-1:0] pStartAdrs    = '0,
  parameter logic [pAdrsWidth-1:0] pStopAdrs     = pAdrsWidth'(33'h100000),
  parameter int                    pBurstLen     = 16,
  parameter int                    pErrCntWidth  = 16
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    i_cfg_done,
  input  logic                    i_start,
  input  logic                    i_loop,
  input  logic [1:0]              i_pattern,
  axi4_mem_tester_if.master       bus,
  output logic                    o_test_run,
  output logic                    o_test_done,
  output logic                    o_test_fail,
  output logic [pErrCntWidth-1:0] o_err_cnt,
  output logic [pAdrsWidth-1:0]   o_fail_addr,
  output logic [15:0]             o_pass_cnt
);
  localparam int                    BEAT_BYTES  = pAxi4BusWidth / 8;
  localparam int                    BEAT_SHIFT  = $clog2(BEAT_BYTES);
  localparam logic [pAdrsWidth-1:0] BURST_BYTES = pAdrsWidth'(BEAT_BYTES * pBurstLen);
  localparam logic [7:0]            LAST_BEAT   = 8'(pBurstLen - 1);

  if (pAxi4BusWidth < 32 || pAxi4BusWidth > 1024 || (pAxi4BusWidth % 32) != 0 ||
      (1 << BEAT_SHIFT) != BEAT_BYTES) begin : g_bad_width
    $error("axi4_mem_tester: pAxi4BusWidth must be a power-of-two multiple of 32, at most 1024");
  end
  if (pBurstLen < 1 || pBurstLen > 256) begin : g_bad_burst
    $error("axi4_mem_tester: pBurstLen must be 1..256");
  end
  if (pStopAdrs <= pStartAdrs || ((pStopAdrs - pStartAdrs) % BURST_BYTES) != 0 ||
      (pStartAdrs % BURST_BYTES) != 0) begin : g_bad_window
    $error("axi4_mem_tester: window must be a non-empty, burst-aligned multiple of the burst size");
  end

  state_e                  state_q, state_d;
  logic [pAdrsWidth-1:0]   addr_q, addr_d, addr_next;
  logic [7:0]              beat_q, beat_d;
  pattern_e                pattern_q, pattern_d;
  logic                    loop_q, loop_d, stop_q, stop_d;
  logic                    done_q, done_d, fail_q, fail_d;
  logic [pErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [pAdrsWidth-1:0]   fail_addr_q, fail_addr_d, err_addr;
  logic [15:0]             pass_cnt_q, pass_cnt_d;
  logic                    gen_load, wgen_adv, rgen_adv, err_event, last_exp;
  logic [pAxi4BusWidth-1:0] wgen_data, rgen_data;

  assign addr_next = addr_q + BURST_BYTES;
  assign last_exp  = (beat_q == LAST_BEAT);

  // Next-state logic, generator control and error accounting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    pattern_d   = pattern_q;
    loop_d      = loop_q;
    stop_d      = stop_q;
    done_d      = done_q;
    fail_d      = fail_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    pass_cnt_d  = pass_cnt_q;
    gen_load    = 1'b0;
    wgen_adv    = 1'b0;
    rgen_adv    = 1'b0;
    err_event   = 1'b0;
    err_addr    = addr_q;
    // A start pulse during a pass only ends looping; the pass itself runs to completion.
    if (state_q != ST_IDLE && i_start) stop_d = 1'b1;
    case (state_q)
      ST_IDLE: if (i_start && i_cfg_done) begin
        state_d     = ST_AW;
        gen_load    = 1'b1;
        pattern_d   = pattern_e'(i_pattern);
        loop_d      = i_loop;
        stop_d      = 1'b0;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        err_cnt_d   = '0;
        fail_addr_d = '0;
        pass_cnt_d  = '0;
        addr_d      = pStartAdrs;
        beat_d      = '0;
      end
      ST_AW: if (bus.i_awready) state_d = ST_W;
      ST_W: if (bus.i_wready) begin
        wgen_adv = 1'b1;
        if (last_exp) begin
          beat_d  = '0;
          state_d = ST_B;
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      ST_B: if (bus.i_bvalid) begin
        err_event = (bus.i_bresp != AXI_RESP_OKAY);
        if (addr_next == pStopAdrs) begin
          addr_d  = pStartAdrs;
          state_d = ST_AR;
        end else begin
          addr_d  = addr_next;
          state_d = ST_AW;
        end
      end
      ST_AR: if (bus.i_arready) state_d = ST_R;
      ST_R: if (bus.i_rvalid) begin
        rgen_adv  = 1'b1;
        err_event = (bus.i_rdata != rgen_data) || (bus.i_rresp != AXI_RESP_OKAY) ||
                    (bus.i_rlast != last_exp);
        err_addr  = addr_q + (pAdrsWidth'(beat_q) << BEAT_SHIFT);
        if (bus.i_rlast || last_exp) begin
          beat_d = '0;
          if (addr_next == pStopAdrs) begin
            addr_d     = pStartAdrs;
            state_d    = ST_DONE;
            done_d     = 1'b1;
            pass_cnt_d = pass_cnt_q + 16'd1;
          end else begin
            addr_d  = addr_next;
            state_d = ST_AR;
          end
        end else begin
          beat_d = beat_q + 8'd1;
        end
      end
      ST_DONE: if (loop_q && !stop_q && !i_start) begin
        state_d  = ST_AW;
        gen_load = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_event) begin
      fail_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) fail_addr_d = err_addr;
    end
  end

  // State and status registers; reset abandons any outstanding transfer.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= ST_IDLE;
      addr_q      <= pStartAdrs;
      beat_q      <= '0;
      pattern_q   <= PAT_ADDR;
      loop_q      <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      pass_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      pattern_q   <= pattern_d;
      loop_q      <= loop_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  mem_pattern_gen #(.pAxi4BusWidth(pAxi4BusWidth)) u_wgen (
    .clk(iCLK), .rst(iRST), .load(gen_load), .advance(wgen_adv),
    .mode(pattern_d), .address(pStartAdrs[31:0]), .o_data(wgen_data)
  );

  mem_pattern_gen #(.pAxi4BusWidth(pAxi4BusWidth)) u_rgen (
    .clk(iCLK), .rst(iRST), .load(gen_load), .advance(rgen_adv),
    .mode(pattern_d), .address(pStartAdrs[31:0]), .o_data(rgen_data)
  );

  assign bus.o_awaddr  = addr_q;
  assign bus.o_awlen   = LAST_BEAT;
  assign bus.o_awsize  = 3'(BEAT_SHIFT);
  assign bus.o_awburst = AXI_BURST_INCR;
  assign bus.o_awvalid = (state_q == ST_AW);
  assign bus.o_wdata   = wgen_data;
  assign bus.o_wstrb   = '1;
  assign bus.o_wlast   = last_exp;
  assign bus.o_wvalid  = (state_q == ST_W);
  assign bus.o_bready  = (state_q == ST_B);
  assign bus.o_araddr  = addr_q;
  assign bus.o_arlen   = LAST_BEAT;
  assign bus.o_arsize  = 3'(BEAT_SHIFT);
  assign bus.o_arburst = AXI_BURST_INCR;
  assign bus.o_arvalid = (state_q == ST_AR);
  assign bus.o_rready  = (state_q == ST_R);

  assign o_test_run  = (state_q != ST_IDLE);
  assign o_test_done = done_q;
  assign o_test_fail = fail_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_fail_addr = fail_addr_q;
  assign o_pass_cnt  = pass_cnt_q;
endmodule

// File: tb/tb_axi4_mem_tester.sv
// Directed bench: a memory-model AXI slave with optional stalls, bit
// corruption and an error response, driven against the tester.
module tb_axi4_mem_tester;
  localparam int W     = 512;
  localparam int AW    = 33;
  localparam int BL    = 16;
  localparam int BEATS = 128;   // 0x2000 window / 64-byte beats

  logic          iCLK = 1'b0;
  logic          iRST;
  logic          i_cfg_done, i_start, i_loop;
  logic [1:0]    i_pattern;
  logic          o_test_run, o_test_done, o_test_fail;
  logic [15:0]   o_err_cnt, o_pass_cnt;
  logic [AW-1:0] o_fail_addr;

  axi4_mem_tester_if #(.pAxi4BusWidth(W), .pAdrsWidth(AW)) bus ();

  axi4_mem_tester #(
    .pAxi4BusWidth(W), .pAdrsWidth(AW), .pStartAdrs(33'h0), .pStopAdrs(33'h2000),
    .pBurstLen(BL), .pErrCntWidth(16)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .i_cfg_done(i_cfg_done), .i_start(i_start),
    .i_loop(i_loop), .i_pattern(i_pattern), .bus(bus),
    .o_test_run(o_test_run), .o_test_done(o_test_done), .o_test_fail(o_test_fail),
    .o_err_cnt(o_err_cnt), .o_fail_addr(o_fail_addr), .o_pass_cnt(o_pass_cnt)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, written by the main sequence only while the DUT is idle.
  bit          stall_en = 0;
  bit          corrupt_en = 0;
  logic [32:0] corrupt_addr = '0;
  bit          bresp_err_en = 0;
  int          bresp_err_burst = 0;

  // Slave model state, written only by the slave process.
  logic [W-1:0] mem [BEATS];
  int           aw_cnt, ar_cnt, b_cnt, w_beat, r_beat;
  int           aw_st, w_st, ar_st, r_st;
  logic [32:0]  w_addr, r_addr, aw_hold, ar_hold;
  logic [W-1:0] w_hold;
  logic         wl_hold;
  bit           b_pending, b_fire, r_fire, r_active;
  bit           aw_stalled, w_stalled, ar_stalled;
  logic [31:0]  first_lane3;

  function automatic int rnd_stall();
    return stall_en ? int'($urandom_range(7, 0)) : 0;
  endfunction

  task automatic slave_clear();
    bus.i_awready = 0; bus.i_wready = 0; bus.i_arready = 0;
    bus.i_bvalid = 0;  bus.i_bresp = 0;
    bus.i_rvalid = 0;  bus.i_rresp = 0;  bus.i_rlast = 0; bus.i_rdata = '0;
    w_beat = BL; r_beat = 0; aw_st = 0; w_st = 0; ar_st = 0; r_st = 0;
    b_pending = 0; b_fire = 0; r_fire = 0; r_active = 0;
    aw_stalled = 0; w_stalled = 0; ar_stalled = 0;
  endtask

  // Slave: decides at each falling edge what the next rising edge will see.
  initial begin
    int          idx;
    logic [32:0] baddr;
    aw_cnt = 0; ar_cnt = 0; b_cnt = 0; first_lane3 = '0; w_addr = '0; r_addr = '0;
    slave_clear();
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        slave_clear();
        continue;
      end
      // write response
      if (b_fire) begin bus.i_bvalid = 0; b_fire = 0; b_cnt++; end
      if (!bus.i_bvalid && b_pending) begin
        bus.i_bvalid = 1;
        bus.i_bresp  = (bresp_err_en && b_cnt == bresp_err_burst) ? 2'b10 : 2'b00;
        b_pending    = 0;
      end
      b_fire = bus.i_bvalid && bus.o_bready;
      // read data
      if (r_fire) begin
        bus.i_rvalid = 0; r_fire = 0; r_beat++;
        if (bus.i_rlast) r_active = 0;
      end
      if (!bus.i_rvalid && r_active) begin
        if (r_st > 0) r_st--;
        else begin
          baddr = r_addr + 33'(r_beat * 64);
          idx   = int'(baddr >> 6);
          bus.i_rdata = (idx < BEATS) ? mem[idx] : '0;
          if (corrupt_en && baddr == corrupt_addr) bus.i_rdata[5] = ~bus.i_rdata[5];
          bus.i_rlast  = (r_beat == BL - 1);
          bus.i_rresp  = 2'b00;
          bus.i_rvalid = 1;
          r_st = rnd_stall();
        end
      end
      r_fire = bus.i_rvalid && bus.o_rready;
      // read address
      if (ar_stalled) begin
        check("ar_hold_valid", bus.o_arvalid, 1);
        check("ar_hold_addr", bus.o_araddr, ar_hold);
      end
      ar_stalled = 0; bus.i_arready = 0;
      if (bus.o_arvalid) begin
        if (ar_st > 0) begin
          ar_st--; ar_stalled = 1; ar_hold = bus.o_araddr;
        end else begin
          bus.i_arready = 1;
          check("ar_fmt", {bus.o_arlen, 3'b0, bus.o_arsize, 2'b0, bus.o_arburst}, {8'd15, 3'b0, 3'd6, 2'b0, 2'b01});
          r_addr = bus.o_araddr; r_beat = 0; r_active = 1; ar_cnt++;
          ar_st = rnd_stall();
        end
      end
      // write address
      if (aw_stalled) begin
        check("aw_hold_valid", bus.o_awvalid, 1);
        check("aw_hold_addr", bus.o_awaddr, aw_hold);
      end
      aw_stalled = 0; bus.i_awready = 0;
      if (bus.o_awvalid) begin
        if (aw_st > 0) begin
          aw_st--; aw_stalled = 1; aw_hold = bus.o_awaddr;
        end else begin
          bus.i_awready = 1;
          check("aw_fmt", {bus.o_awlen, 3'b0, bus.o_awsize, 2'b0, bus.o_awburst}, {8'd15, 3'b0, 3'd6, 2'b0, 2'b01});
          w_addr = bus.o_awaddr; w_beat = 0; aw_cnt++;
          aw_st = rnd_stall();
        end
      end
      // write data
      if (w_stalled) begin
        check("w_hold_valid", bus.o_wvalid, 1);
        check("w_hold_data", 64'(bus.o_wdata != w_hold), 0);
        check("w_hold_last", bus.o_wlast, wl_hold);
      end
      w_stalled = 0; bus.i_wready = 0;
      if (bus.o_wvalid) begin
        if (w_st > 0) begin
          w_st--; w_stalled = 1; w_hold = bus.o_wdata; wl_hold = bus.o_wlast;
        end else begin
          bus.i_wready = 1;
          idx = int'(w_addr >> 6) + w_beat;
          if (idx < BEATS) mem[idx] = bus.o_wdata;
          check("wlast", bus.o_wlast, (w_beat == BL - 1));
          check("wstrb", bus.o_wstrb, {64{1'b1}});
          if (w_addr == 0 && w_beat == 0) first_lane3 = bus.o_wdata[127:96];
          if (w_beat == BL - 1) b_pending = 1;
          w_beat++;
          w_st = rnd_stall();
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] mode, input logic loop);
    @(negedge iCLK);
    i_pattern = mode; i_loop = loop; i_start = 1;
    @(negedge iCLK);
    i_start = 0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge iCLK);
      ok = !o_test_run;
    end
    check({tag, "_finished"}, ok, 1);
  endtask

  task automatic check_result(input string tag, input logic fail, input int errs, input int passes);
    check({tag, "_done"}, o_test_done, 1);
    check({tag, "_fail"}, o_test_fail, fail);
    check({tag, "_err_cnt"}, o_err_cnt, 64'(errs));
    check({tag, "_pass_cnt"}, o_pass_cnt, 64'(passes));
  endtask

  initial begin
    int  aw0, ar0;
    bit  ok;
    iRST = 1; i_cfg_done = 0; i_start = 0; i_loop = 0; i_pattern = 0;
    repeat (3) @(negedge iCLK);
    check("rst_status", {o_test_run, o_test_done, o_test_fail}, 0);
    check("rst_counts", {o_err_cnt, o_pass_cnt}, 0);
    check("rst_fail_addr", o_fail_addr, 0);
    check("rst_chan", {bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready}, 0);
    check("rst_addr", bus.o_awaddr, 0);
    iRST = 0;

    // start is ignored until calibration completes
    pulse_start(2'd0, 0);
    repeat (3) @(negedge iCLK);
    check("no_cfg_run", o_test_run, 0);
    i_cfg_done = 1;

    // clean pass, address pattern
    aw0 = aw_cnt; ar0 = ar_cnt;
    pulse_start(2'd0, 0);
    check("clean_run", o_test_run, 1);
    wait_idle("clean");
    check_result("clean", 0, 0, 1);
    check("clean_lane3", first_lane3, 32'h0000_000C);
    check("clean_aw_bursts", 64'(aw_cnt - aw0), 8);
    check("clean_ar_bursts", 64'(ar_cnt - ar0), 8);
    check("clean_beat1_lane0", mem[1][31:0], 32'h40);
    check("clean_last_lane15", mem[127][511:480], 32'h1FFC);

    // inverted address pattern
    pulse_start(2'd1, 0);
    wait_idle("inv");
    check_result("inv", 0, 0, 1);
    check("inv_beat0_lane0", mem[0][31:0], 32'hFFFF_FFFF);
    check("inv_beat2_lane1", mem[2][63:32], 32'hFFFF_FF7B);

    // walking one, indexed by beat within the pass
    pulse_start(2'd2, 0);
    wait_idle("walk");
    check_result("walk", 0, 0, 1);
    check("walk_beat0_lane1", mem[0][63:32], 32'h2);
    check("walk_beat31_lane1", mem[31][63:32], 32'h1);
    check("walk_beat33_lane0", mem[33][31:0], 32'h2);

    // single-bit corruption on read
    corrupt_en = 1; corrupt_addr = 33'h1040;
    pulse_start(2'd0, 0);
    wait_idle("corrupt");
    check_result("corrupt", 1, 1, 1);
    check("corrupt_fail_addr", o_fail_addr, 33'h1040);
    corrupt_en = 0;

    // random backpressure on every channel
    stall_en = 1;
    aw0 = aw_cnt; ar0 = ar_cnt;
    pulse_start(2'd0, 0);
    wait_idle("stall");
    check_result("stall", 0, 0, 1);
    check("stall_aw_bursts", 64'(aw_cnt - aw0), 8);
    check("stall_ar_bursts", 64'(ar_cnt - ar0), 8);
    stall_en = 0;

    // SLVERR on the third write burst
    bresp_err_en = 1; bresp_err_burst = b_cnt + 2;
    pulse_start(2'd0, 0);
    wait_idle("bresp");
    check_result("bresp", 1, 1, 1);
    check("bresp_fail_addr", o_fail_addr, 33'h800);
    bresp_err_en = 0;

    // loop mode with LFSR data, stopped by a start pulse in the fourth pass
    pulse_start(2'd3, 1);
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge iCLK);
      ok = (o_pass_cnt == 16'd3);
    end
    check("loop_reach3", ok, 1);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge iCLK);
      ok = bus.o_wvalid;
    end
    check("loop_pass4_w", ok, 1);
    i_start = 1;
    @(negedge iCLK);
    i_start = 0; i_loop = 0;
    wait_idle("loop");
    check_result("loop", 0, 0, 4);
    check("lfsr_beat0_lane0", mem[0][31:0], 32'hD650_8003);
    check("lfsr_beat0_lane1", mem[0][63:32], 32'hEB08_4002);

    // reset in the middle of the first write burst
    pulse_start(2'd0, 0);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge iCLK);
      #2;
      ok = (w_beat == 7);
    end
    check("mid_w_reached", ok, 1);
    iRST = 1;
    #1;
    check("mid_rst_chan", {bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready}, 0);
    check("mid_rst_run", o_test_run, 0);
    repeat (2) @(negedge iCLK);
    check("mid_rst_status", {o_test_done, o_test_fail, o_err_cnt, o_pass_cnt}, 0);
    iRST = 0;
    pulse_start(2'd0, 0);
    wait_idle("after_rst");
    check_result("after_rst", 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
